// File: rtl/rv_soc_apb_8b_master.sv
// 8-bit APB initiator. Each byte/half/word request becomes a little-endian
// sequence of 8-bit APB transfers, and the read bytes return as one response.
module rv_soc_apb_8b_master #(
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [PADDR_SIZE-1:0] req_addr,
  input  logic [2:0]            req_prot,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [2:0]            PPROT,
  output logic                  PWRITE,
  output logic                  PSTRB,
  output logic [PADDR_SIZE-1:0] PADDR,
  output logic [7:0]            PWDATA,
  input  logic [7:0]            PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (PDATA_SIZE != 8) begin : g_bad_pdata
    $error("rv_soc_apb_8b_master supports only PDATA_SIZE == 8");
  end

  localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TO_EN  = (TIMEOUT != 0);
  localparam logic [TW-1:0]   TLIM   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                r_state;
  logic [31:0]           r_wdata;
  logic [PADDR_SIZE-1:0] r_addr;
  logic [1:0]            r_k;
  logic [1:0]            r_last;
  logic [TW-1:0]         r_tcnt;

  logic                  w_misalign;
  logic                  w_last;
  logic [1:0]            w_k_next;
  logic                  w_timeout;

  function automatic logic [7:0] f_byte(input logic [31:0] d, input logic [1:0] k);
    return d[{k, 3'b000} +: 8];
  endfunction

  assign req_ready = (r_state == IDLE);
  assign w_last    = (r_k == r_last);
  assign w_k_next  = r_k + 2'd1;
  assign w_timeout = TO_EN && (r_tcnt == TLIM);

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = req_addr[0];
      2'd2:    w_misalign = |req_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  // Request data is only consumed while a transfer is in flight, so it needs no reset.
  always_ff @(posedge PCLK) begin
    if (r_state == IDLE && req_valid) begin
      r_wdata <= req_wdata;
      r_addr  <= req_addr;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_k       <= 2'd0;
      r_last    <= 2'd0;
      r_tcnt    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PSTRB     <= 1'b0;
      PPROT     <= 3'd0;
      PADDR     <= '0;
      PWDATA    <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_k       <= 2'd0;
            r_last    <= (req_size == 2'd2) ? 2'd3 : ((req_size == 2'd1) ? 2'd1 : 2'd0);
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            if (w_misalign) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              r_state   <= RESP;
            end else begin
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              PADDR   <= req_addr;
              PWDATA  <= req_wdata[7:0];
              PWRITE  <= req_write;
              PSTRB   <= req_write;
              PPROT   <= req_prot;
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_tcnt  <= '0;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            if (!PWRITE) rsp_rdata[{r_k, 3'b000} +: 8] <= PRDATA;
            if (PSLVERR || w_last) begin
              PSEL      <= 1'b0;
              PENABLE   <= 1'b0;
              rsp_err   <= PSLVERR;
              rsp_valid <= 1'b1;
              r_state   <= RESP;
            end else begin
              // Back-to-back transfer: PSEL stays high, next byte goes straight to SETUP.
              r_k     <= w_k_next;
              PENABLE <= 1'b0;
              PADDR   <= r_addr + PADDR_SIZE'(w_k_next);
              PWDATA  <= f_byte(r_wdata, w_k_next);
              r_state <= SETUP;
            end
          end else if (w_timeout) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_soc_apb_8b_master.sv
// Bench for rv_soc_apb_8b_master: vector table of requests, an APB slave model
// with wait/error/stall injection, and queues of expected transfers and responses.
module tb_rv_soc_apb_8b_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [2:0]  req_prot;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PSTRB;
  logic [2:0]  PPROT;
  logic [15:0] PADDR;
  logic [7:0]  PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  rv_soc_apb_8b_master #(.PADDR_SIZE(16), .PDATA_SIZE(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_prot(req_prot), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PWRITE(PWRITE), .PSTRB(PSTRB),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    logic [2:0]  prot;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  typedef struct {
    bit        wr;
    bit [1:0]  size;
    bit [15:0] addr;
    bit [31:0] wdata;
    bit [2:0]  prot;
    int        wait_byte;
    int        wait_cyc;
    int        err_byte;
    bit        stuck;
    int        hold;
    bit [31:0] exp_rdata;
    bit        exp_err;
    int        exp_lat;
    int        exp_nx;
  } vec_t;

  xfer_t exp_x[$];
  rsp_t  exp_r[$];

  logic [7:0] mem [0:65535];
  int sl_wait_byte, sl_wait_cyc, sl_err_byte, byte_idx, acc_waits;
  bit sl_stuck, psel_seen;

  // APB slave model: decides PREADY/PRDATA/PSLVERR on the falling edge for the next rising edge
  initial begin
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'd0;
    forever begin
      int    want;
      xfer_t e;
      @(negedge PCLK);
      if (PSEL) psel_seen = 1'b1;
      if (PSEL && PENABLE && !PRESET) begin
        want = sl_stuck ? 1000000 : ((byte_idx == sl_wait_byte) ? sl_wait_cyc : 0);
        if (acc_waits < want) begin
          PREADY  = 1'b0;
          PSLVERR = 1'b0;
          acc_waits++;
        end else begin
          PREADY    = 1'b1;
          PRDATA    = mem[PADDR];
          PSLVERR   = (byte_idx == sl_err_byte);
          acc_waits = 0;
          byte_idx++;
          if (exp_x.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer actual=paddr_0x%0h required=no_transfer", PADDR);
          end else begin
            e = exp_x.pop_front();
            chk("xfer_paddr", 32'(PADDR), 32'(e.addr));
            chk("xfer_pwrite", 32'(PWRITE), 32'(e.wr));
            chk("xfer_pstrb", 32'(PSTRB), 32'(e.wr));
            chk("xfer_pprot", 32'(PPROT), 32'(e.prot));
            if (e.wr) chk("xfer_pwdata", 32'(PWDATA), 32'(e.wdata));
          end
        end
      end else begin
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        acc_waits = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    rsp_t r;
    int   lat;
    bit   got;
    logic [31:0] held;
    @(negedge PCLK);
    sl_wait_byte = v.wait_byte;
    sl_wait_cyc  = v.wait_cyc;
    sl_err_byte  = v.err_byte;
    sl_stuck     = v.stuck;
    byte_idx     = 0;
    acc_waits    = 0;
    psel_seen    = 1'b0;
    for (int k = 0; k < v.exp_nx; k++) begin
      xfer_t x;
      x.addr  = v.addr + 16'(k);
      x.wdata = v.wdata[8*k +: 8];
      x.wr    = v.wr;
      x.prot  = v.prot;
      exp_x.push_back(x);
    end
    r.rdata = v.exp_rdata;
    r.err   = v.exp_err;
    r.lat   = v.exp_lat;
    exp_r.push_back(r);
    req_write = v.wr; req_size = v.size; req_addr = v.addr;
    req_prot  = v.prot; req_wdata = v.wdata; req_valid = 1'b1;
    chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = 16'($urandom);
    req_prot  = 3'($urandom);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge PCLK);
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    r = exp_r.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_rsp_wait actual=no_rsp_valid required=rsp_valid_at_%0d", tag, r.lat);
    end else begin
      chk({tag, "_latency"}, 32'(lat), 32'(r.lat));
      chk({tag, "_rdata"}, rsp_rdata, r.rdata);
      chk({tag, "_err"}, 32'(rsp_err), 32'(r.err));
      chk({tag, "_psel_resp"}, 32'({PSEL, PENABLE}), 32'd0);
      chk({tag, "_req_ready_resp"}, 32'(req_ready), 32'd0);
      held = rsp_rdata;
      for (int h = 0; h < v.hold; h++) begin
        req_valid = 1'b1;
        @(negedge PCLK);
        chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_hold_rdata"}, rsp_rdata, held);
        chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge PCLK);
      #1;
      rsp_ready = 1'b0;
      @(negedge PCLK);
      chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_back_idle"}, 32'(req_ready), 32'd1);
    end
    chk({tag, "_xfers_left"}, 32'(exp_x.size()), 32'd0);
    exp_x.delete();
    if (v.exp_nx == 0 && !v.stuck) chk({tag, "_no_psel"}, 32'(psel_seen), 32'd0);
  endtask

  localparam int NV = 11;
  vec_t vecs [NV];
  vec_t post;

  initial begin
    bit seen;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'h0102] = 8'hAB;
    mem[16'h0103] = 8'hCD;

    //         wr    size   addr      wdata          prot    wb  wc  eb  stk  hold exp_rdata      err   lat nx
    vecs[0]  = '{1'b1, 2'd2, 16'h0010, 32'h44332211, 3'b010, -1, 0, -1, 1'b0, 0, 32'h00000000, 1'b0, 9,  4};
    vecs[1]  = '{1'b0, 2'd1, 16'h0102, 32'h00000000, 3'b001,  0, 2, -1, 1'b0, 5, 32'h0000CDAB, 1'b0, 7,  2};
    vecs[2]  = '{1'b1, 2'd2, 16'h0020, 32'hDEADBEEF, 3'b000, -1, 0,  1, 1'b0, 0, 32'h00000000, 1'b1, 5,  2};
    vecs[3]  = '{1'b0, 2'd0, 16'h0030, 32'h00000000, 3'b000, -1, 0, -1, 1'b1, 0, 32'h00000000, 1'b1, 18, 0};
    vecs[4]  = '{1'b0, 2'd2, 16'h0002, 32'h00000000, 3'b000, -1, 0, -1, 1'b0, 0, 32'h00000000, 1'b1, 1,  0};
    vecs[5]  = '{1'b0, 2'd3, 16'h0000, 32'h00000000, 3'b000, -1, 0, -1, 1'b0, 0, 32'h00000000, 1'b1, 1,  0};
    vecs[6]  = '{1'b0, 2'd2, 16'h0040, 32'h00000000, 3'b101, -1, 0, -1, 1'b0, 0, 32'h19181B1A, 1'b0, 9,  4};
    vecs[7]  = '{1'b0, 2'd2, 16'h0040, 32'h00000000, 3'b000, -1, 0,  1, 1'b0, 0, 32'h00001B1A, 1'b1, 5,  2};
    vecs[8]  = '{1'b1, 2'd1, 16'h0011, 32'h0000BEEF, 3'b000, -1, 0, -1, 1'b0, 0, 32'h00000000, 1'b1, 1,  0};
    vecs[9]  = '{1'b0, 2'd0, 16'h0055, 32'h00000000, 3'b011, -1, 0, -1, 1'b0, 3, 32'h0000000F, 1'b0, 3,  1};
    vecs[10] = '{1'b1, 2'd0, 16'h00FF, 32'h000000A5, 3'b100, -1, 0, -1, 1'b0, 0, 32'h00000000, 1'b0, 3,  1};
    post     = '{1'b0, 2'd0, 16'h0061, 32'h00000000, 3'b000, -1, 0, -1, 1'b0, 0, 32'h0000003B, 1'b0, 3,  1};

    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_addr = 16'd0; req_prot = 3'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    sl_wait_byte = -1; sl_wait_cyc = 0; sl_err_byte = -1; sl_stuck = 1'b0;
    byte_idx = 0; acc_waits = 0; psel_seen = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite_pstrb", 32'({PWRITE, PSTRB}), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata_pprot", 32'({PWDATA, PPROT}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    PRESET = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while a word read is stalled in ACCESS
    @(negedge PCLK);
    sl_stuck = 1'b1; sl_wait_byte = -1; sl_err_byte = -1;
    byte_idx = 0; acc_waits = 0;
    req_write = 1'b0; req_size = 2'd2; req_addr = 16'h0040; req_prot = 3'd0;
    req_wdata = 32'd0; req_valid = 1'b1;
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) seen = 1'b1;
    end
    chk("mid_rst_reached_access", 32'(seen), 32'd1);
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("mid_rst_psel", 32'(PSEL), 32'd0);
    chk("mid_rst_penable", 32'(PENABLE), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    sl_stuck = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    run_vec(post, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
